// File: rtl/x_imem_loader.sv
// Instruction memory that is filled from a byte-serial loader stream after reset
// and then serves single-word core fetches with a fixed, configurable latency.
module x_imem_loader #(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        o_accept,
    output logic [31:0] o_data,
    input  logic        i_ld_valid,
    input  logic [7:0]  i_ld_byte,
    output logic        o_ld_ready,
    output logic        o_busy
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [16:0] DEPTH_CNT = 17'(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_LAST  = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;
    localparam logic [31:0] NOP_WORD  = 32'h00000013;

    typedef enum logic [2:0] {
        LD_HDR,
        LD_DATA,
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  lane;
    logic [1:0]  lane_next;
    logic [15:0] wptr;
    logic [15:0] wptr_next;
    logic [15:0] n_words;
    logic [15:0] n_next;
    logic [3:0]  lat_cnt;
    logic [3:0]  lat_next;

    logic [7:0]  hdr_lo;
    logic [23:0] word_buf;
    logic [29:0] idx;
    logic [31:0] rdata;
    logic [31:0] mem [DEPTH_WORDS];

    logic        mem_we;
    logic        cap_req;
    logic [AW-1:0] rd_addr;
    logic [15:0] hdr_word;
    logic [16:0] wptr_inc;
    logic        wptr_in_range;
    logic [1:0]  unused_addr_bits;

    assign hdr_word         = {i_ld_byte, hdr_lo};
    assign wptr_inc         = {1'b0, wptr} + 17'd1;
    assign wptr_in_range    = ({1'b0, wptr} < DEPTH_CNT);
    assign unused_addr_bits = i_addr[1:0];

    // The read port follows the live address while idle so a latency of one still works.
    assign rd_addr = (state == IDLE) ? i_addr[AW+1:2] : idx[AW-1:0];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state   <= LD_HDR;
            lane    <= 2'd0;
            wptr    <= 16'd0;
            n_words <= 16'd0;
            lat_cnt <= 4'd0;
        end else begin
            state   <= state_next;
            lane    <= lane_next;
            wptr    <= wptr_next;
            n_words <= n_next;
            lat_cnt <= lat_next;
        end
    end

    always_comb begin
        state_next = state;
        lane_next  = lane;
        wptr_next  = wptr;
        n_next     = n_words;
        lat_next   = lat_cnt;
        mem_we     = 1'b0;
        cap_req    = 1'b0;
        o_accept   = 1'b0;
        o_data     = 32'd0;
        o_ld_ready = 1'b0;
        o_busy     = 1'b0;

        case (state)
            LD_HDR: begin
                o_ld_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_ld_valid) begin
                    if (lane == 2'd0) begin
                        lane_next = 2'd1;
                    end else begin
                        lane_next  = 2'd0;
                        n_next     = hdr_word;
                        wptr_next  = 16'd0;
                        state_next = (hdr_word == 16'd0) ? IDLE : LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                o_ld_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_ld_valid) begin
                    if (lane != 2'd3) begin
                        lane_next = lane + 2'd1;
                    end else begin
                        // Words past the end of memory are swallowed so the stream stays framed.
                        lane_next = 2'd0;
                        wptr_next = wptr_inc[15:0];
                        mem_we    = wptr_in_range;
                        if (wptr_inc == {1'b0, n_words}) begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            IDLE: begin
                if (i_valid) begin
                    cap_req    = 1'b1;
                    lat_next   = 4'd0;
                    state_next = (READ_LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!i_valid) begin
                    state_next = IDLE;
                end else if (lat_cnt == LAT_LAST) begin
                    state_next = RESP;
                end else begin
                    lat_next = lat_cnt + 4'd1;
                end
            end
            RESP: begin
                o_accept   = 1'b1;
                o_data     = (idx >= DEPTH_IDX) ? NOP_WORD : rdata;
                state_next = IDLE;
            end
            default: begin
                state_next = LD_HDR;
            end
        endcase
    end

    // Datapath storage carries no reset; its contents are qualified by the control state.
    always_ff @(posedge i_clk) begin
        if (state == LD_HDR && i_ld_valid && lane == 2'd0) begin
            hdr_lo <= i_ld_byte;
        end
        if (state == LD_DATA && i_ld_valid) begin
            case (lane)
                2'd0:    word_buf[7:0]   <= i_ld_byte;
                2'd1:    word_buf[15:8]  <= i_ld_byte;
                2'd2:    word_buf[23:16] <= i_ld_byte;
                default: word_buf        <= word_buf;
            endcase
        end
        if (mem_we) begin
            mem[wptr[AW-1:0]] <= {i_ld_byte, word_buf};
        end
        if (cap_req) begin
            idx <= i_addr[31:2];
        end
        if (state != RESP) begin
            rdata <= mem[rd_addr];
        end
    end

endmodule
